fifo_decim_read_master: RTL and testbench
=========================================

Name: fifo_decim_read_master

Overview:
Avalon-MM read master that drains the read slave of the dual-clock sample FIFO in the rdclock domain. It obeys waitrequest, which the slave drives from FIFO empty, and captures readdata at a fixed read latency. It keeps one word in every DECIM and presents the kept words on an Avalon-ST source with ready/valid backpressure. It sits between the CDC FIFO and the downstream decimated-sample consumer.

Parameters:
DATA_W, 32, word width; must equal the FIFO width.
DECIM, 4, decimation ratio; power of two, 1..64.
READ_LATENCY, 1, cycles from read acceptance to valid readdata (FIFO non-showahead gives 1); range 1..4.
OUT_DEPTH, 4, output buffer entries; power of two, at least 2.

Ports:
rdclock  in  1  single clock for the whole block
rdreset_n  in  1  synchronous, active-low reset
enable  in  1  1 = allow new read requests
avm_read  out  1  Avalon-MM read request to the FIFO read slave
avm_waitrequest  in  1  slave stall; high = FIFO empty
avm_readdata  in  DATA_W  FIFO q
st_data  out  DATA_W  decimated sample
st_valid  out  1  st_data valid
st_ready  in  1  sink accepts the current word
kept_count  out  16  kept words pushed to the output buffer; wraps
busy  out  1  read outstanding, in-flight data, or output buffer non-empty

Behaviour:
- Reset (synchronous, rdreset_n=0 at a rdclock edge):
  - avm_read=0, st_valid=0, kept_count=0, busy=0.
  - Phase counter=0, credit counter=OUT_DEPTH, latency pipe cleared, output buffer empty.
  - Data returning in flight across reset is discarded. The FIFO word is lost; this is accepted behaviour.
- Acceptance: a read is accepted in a cycle where avm_read=1 and avm_waitrequest=0.
- Capture: for an accepted read, avm_readdata is captured exactly READ_LATENCY cycles later. A READ_LATENCY-deep shift register carries a keep flag per accepted read.
- Phase counter: 0..DECIM-1, increments on every acceptance and wraps to 0.
  - An acceptance with phase==0 is a kept read; all other acceptances are dropped and never enter the buffer.
  - DECIM=1: every read is kept.
- Credits: credit = free buffer entries minus kept reads in flight.
  - Decrement on a kept acceptance; increment on an st_valid && st_ready pop.
  - If both happen in the same cycle, credit is unchanged.
- Request state machine, 2 states:
  - IDLE: avm_read=0. Go to REQ when enable=1 and (phase!=0 or credit>0).
  - REQ: avm_read=1.
    - On acceptance: stay in REQ if enable=1 and (next phase!=0 or next credit>0); otherwise go to IDLE.
    - While avm_waitrequest=1: hold avm_read=1 regardless of enable. A posted request is never withdrawn.
- Throughput: back-to-back acceptances, one per cycle, while the FIFO is non-empty and credit allows.
- Output buffer: synchronous FIFO of OUT_DEPTH entries. st_valid = not empty; st_data = head word.
  - Push and pop in the same cycle are both allowed.
  - The credit scheme guarantees no push when full. A bench assertion flags any overflow.
  - st_data is held stable while st_valid=1 and st_ready=0.
- kept_count increments on each buffer push and wraps 0xFFFF -> 0x0000.
- enable=0 stops issuing new requests; already-accepted data still lands in the buffer.

Optional Feature:
Macro: FIFO_DECIM_AVG_EN.
- Defined:
  - Every accepted word feeds a signed accumulator of DATA_W+log2(DECIM) bits.
  - When the word from the phase==DECIM-1 acceptance arrives, push (accumulator including that word) >>> log2(DECIM), truncated to DATA_W bits, then clear the accumulator.
  - A credit is consumed at the phase==0 acceptance of each group.
  - Reset clears the accumulator.
- Undefined: pure drop decimation as described in Behaviour; no accumulator logic exists.

Test Plan:
- Preload 8 FIFO words 0x10..0x17, DECIM=4, enable=1, st_ready=1 -> st_data 0x10 then 0x14; kept_count=2; avm_read held 8 accepting cycles.
- waitrequest=1 for 5 cycles while avm_read=1, enable dropped to 0 in cycle 2 -> avm_read stays 1 until acceptance, then goes to 0; no words lost.
- st_ready=0, 40 words supplied, OUT_DEPTH=4 -> exactly 4 words buffered (0x0,0x4,0x8,0xC), requests stop with phase=0 and credit=0, no overflow. Release st_ready -> stream resumes at 0x10.
- Pulse reset mid-stream one cycle after acceptance of word 0x20 (phase 0) -> st_valid=0 next cycle, word 0x20 not output, kept_count=0, next kept word is the next accepted read.
- DECIM=1, READ_LATENCY=2, continuous words 0..99 -> 100 outputs in order, one per cycle after a 2-cycle fill, kept_count=100.
- FIFO_DECIM_AVG_EN, DECIM=4, input 4, 8, -4, 0 (signed) -> single output 0x00000002.

Source files
------------

// File: rtl/fifo_decim_read_master.sv
// fifo_decim_read_master: Avalon-MM FIFO read master that keeps 1 word in DECIM and streams it on Avalon-ST.
// Optional FIFO_DECIM_AVG_EN: push the signed group average instead of the phase-0 word. Rev 1.0
`default_nettype none

module fifo_decim_read_master #(
  parameter int DATA_W       = 32,
  parameter int DECIM        = 4,
  parameter int READ_LATENCY = 1,
  parameter int OUT_DEPTH    = 4
) (
  input  logic              rdclock,
  input  logic              rdreset_n,
  input  logic              enable,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic [15:0]       kept_count,
  output logic              busy
);

  localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int SH   = $clog2(DECIM);
  localparam int AW   = $clog2(OUT_DEPTH);
  localparam int CW   = AW + 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);
  localparam logic [CW-1:0]   CR_FULL = CW'(OUT_DEPTH);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

  state_t                  state;
  logic [PH_W-1:0]         phase;
  logic [PH_W-1:0]         phase_nxt;
  logic [CW-1:0]           credit;
  logic [CW-1:0]           credit_nxt;
  logic                    accept;
  logic                    kept_acc;
  logic                    pop;
  logic                    push;
  logic                    go_on;
  logic [DATA_W-1:0]       push_data;
  logic [READ_LATENCY-1:0] pipe_v;
  logic [DATA_W-1:0]       mem [OUT_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [CW-1:0]           count;

  assign accept    = avm_read & ~avm_waitrequest;
  assign kept_acc  = accept & (phase == '0);
  assign st_valid  = (count != '0);
  assign st_data   = mem[rd_ptr];
  assign pop       = st_valid & st_ready;
  assign phase_nxt = !accept ? phase : ((phase == PH_LAST) ? '0 : phase + PH_W'(1));

  always_comb begin
    credit_nxt = credit;
    if (kept_acc && !pop)
      credit_nxt = credit - CW'(1);
    else if (!kept_acc && pop)
      credit_nxt = credit + CW'(1);
  end

  // A group already started must finish even with zero credit, since only phase-0 reads consume one.
  assign go_on = enable & ((phase_nxt != '0) | (credit_nxt != '0));

  always_ff @(posedge rdclock) begin
    if (!rdreset_n) begin
      state    <= S_IDLE;
      avm_read <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable && ((phase != '0) || (credit != '0))) begin
            state    <= S_REQ;
            avm_read <= 1'b1;
          end
        end
        S_REQ: begin
          if (accept && !go_on) begin
            state    <= S_IDLE;
            avm_read <= 1'b0;
          end
        end
        default: begin
          state    <= S_IDLE;
          avm_read <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge rdclock) begin
    if (!rdreset_n) begin
      phase  <= '0;
      credit <= CR_FULL;
    end else begin
      phase  <= phase_nxt;
      credit <= credit_nxt;
    end
  end

`ifdef FIFO_DECIM_AVG_EN
  localparam int AC_W = DATA_W + SH;

  logic [READ_LATENCY-1:0] pipe_last;
  logic signed [AC_W-1:0]  acc;
  logic signed [AC_W-1:0]  acc_sum;
  logic signed [AC_W-1:0]  acc_shr;

  assign acc_sum   = acc + AC_W'($signed(avm_readdata));
  assign acc_shr   = acc_sum >>> SH;
  assign push      = pipe_v[READ_LATENCY-1] & pipe_last[READ_LATENCY-1];
  assign push_data = acc_shr[DATA_W-1:0];

  always_ff @(posedge rdclock) begin
    if (!rdreset_n) begin
      pipe_v    <= '0;
      pipe_last <= '0;
      acc       <= '0;
    end else begin
      pipe_v[0]    <= accept;
      pipe_last[0] <= accept & (phase == PH_LAST);
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_v[i]    <= pipe_v[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
      if (pipe_v[READ_LATENCY-1])
        acc <= pipe_last[READ_LATENCY-1] ? '0 : acc_sum;
    end
  end
`else
  assign push      = pipe_v[READ_LATENCY-1];
  assign push_data = avm_readdata;

  always_ff @(posedge rdclock) begin
    if (!rdreset_n) begin
      pipe_v <= '0;
    end else begin
      pipe_v[0] <= kept_acc;
      for (int i = 1; i < READ_LATENCY; i++)
        pipe_v[i] <= pipe_v[i-1];
    end
  end
`endif

  // Credits guarantee a free entry for every push, so no full check here.
  always_ff @(posedge rdclock) begin
    if (push)
      mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge rdclock) begin
    if (!rdreset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      kept_count <= '0;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + AW'(1);
        kept_count <= kept_count + 16'd1;
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign busy = avm_read | (|pipe_v) | st_valid;

endmodule

`default_nettype wire

// File: tb/tb_fifo_decim_read_master.sv
// Directed bench for fifo_decim_read_master with behavioural FIFO read-slave models.
`timescale 1ns/1ps

module tb_fifo_decim_read_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, enable, st_ready, flush, enable2, st_ready2;

  logic        read1, wait1, valid1, busy1;
  logic [31:0] q1, data1;
  logic [15:0] kc1;
  logic        read2, wait2, valid2, busy2;
  logic [31:0] q2, q2a, data2;
  logic [15:0] kc2;

  logic [31:0] mem1 [256];
  logic [31:0] mem2 [256];
  int wr1 = 0, rd1 = 0, wr2 = 0, rd2 = 0;
  int acc1 = 0, pops1 = 0, ovf = 0, cyc = 0, first2 = 0, last2 = 0;
  logic [31:0] outq1[$];
  logic [31:0] out2[$];
  int nchk = 0, nerr = 0;

  fifo_decim_read_master #(.DATA_W(32), .DECIM(4), .READ_LATENCY(1), .OUT_DEPTH(4)) dut (
    .rdclock(clk), .rdreset_n(rst_n), .enable(enable), .avm_read(read1),
    .avm_waitrequest(wait1), .avm_readdata(q1), .st_data(data1), .st_valid(valid1),
    .st_ready(st_ready), .kept_count(kc1), .busy(busy1));

  fifo_decim_read_master #(.DATA_W(32), .DECIM(1), .READ_LATENCY(2), .OUT_DEPTH(4)) dut2 (
    .rdclock(clk), .rdreset_n(rst_n), .enable(enable2), .avm_read(read2),
    .avm_waitrequest(wait2), .avm_readdata(q2), .st_data(data2), .st_valid(valid2),
    .st_ready(st_ready2), .kept_count(kc2), .busy(busy2));

  // Non-showahead FIFO slave: waitrequest while empty, q one cycle after acceptance.
  assign wait1 = (rd1 == wr1);
  assign wait2 = (rd2 == wr2);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (flush) begin
      rd1 <= wr1;
      acc1 <= 0;
      outq1.delete();
      rd2 <= wr2;
      out2.delete();
    end else begin
      if (read1 && !wait1) begin
        q1   <= mem1[rd1];
        rd1  <= rd1 + 1;
        acc1 <= acc1 + 1;
      end
      if (valid1 && st_ready) outq1.push_back(data1);
      if (read2 && !wait2) begin
        q2a <= mem2[rd2];
        rd2 <= rd2 + 1;
      end
      if (valid2 && st_ready2) begin
        if (out2.size() == 0) first2 <= cyc;
        last2 <= cyc;
        out2.push_back(data2);
      end
    end
    q2 <= q2a;
  end

  // Output-buffer occupancy seen from the ports: pushes (kept_count) minus pops.
  always @(posedge clk) begin
    if (!rst_n) pops1 <= 0;
    else begin
      if (valid1 && st_ready) pops1 <= pops1 + 1;
      if (16'(kc1 - 16'(pops1)) > 16'd4) ovf <= ovf + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load1(input logic [31:0] v);
    mem1[wr1] = v;
    wr1++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b1;
    tick(2);
    flush = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; st_ready = 1'b0; flush = 1'b1;
    enable2 = 1'b0; st_ready2 = 1'b0;
    tick(2);
    check("rst_read", 32'(read1), 32'd0);
    check("rst_valid", 32'(valid1), 32'd0);
    check("rst_kept", 32'(kc1), 32'd0);
    check("rst_busy", 32'(busy1), 32'd0);
    flush = 1'b0;
    rst_n = 1'b1;
    tick(1);

`ifdef FIFO_DECIM_AVG_EN
    st_ready = 1'b1;
    load1(32'd4); load1(32'd8); load1(32'hFFFF_FFFC); load1(32'd0);
    enable = 1'b1;
    tick(20);
    check("avg_cnt", 32'(outq1.size()), 32'd1);
    check("avg_0", outq1[0], 32'h0000_0002);
    check("avg_kept", 32'(kc1), 32'd1);
    load1(32'd1); load1(32'd2); load1(32'd3); load1(32'd4);
    load1(32'hFFFF_FFF8); load1(32'hFFFF_FFF8); load1(32'hFFFF_FFF8); load1(32'hFFFF_FFFB);
    tick(30);
    check("avg_cnt2", 32'(outq1.size()), 32'd3);
    check("avg_1", outq1[1], 32'h0000_0002);
    check("avg_2", outq1[2], 32'hFFFF_FFF8);
    check("avg_kept2", 32'(kc1), 32'd3);
`else
    // Eight words 0x10..0x17 -> keep 0x10 and 0x14; master then waits on empty FIFO.
    for (int i = 0; i < 8; i++) load1(32'h10 + 32'(i));
    enable = 1'b1; st_ready = 1'b1;
    tick(30);
    check("t1_accepts", 32'(acc1), 32'd8);
    check("t1_cnt", 32'(outq1.size()), 32'd2);
    check("t1_out0", outq1[0], 32'h10);
    check("t1_out1", outq1[1], 32'h14);
    check("t1_kept", 32'(kc1), 32'd2);
    check("t1_read_held", 32'(read1), 32'd1);

    // Posted request survives enable dropping while stalled.
    tick(2);
    enable = 1'b0;
    tick(3);
    check("t2_hold", 32'(read1), 32'd1);
    load1(32'h18);
    tick(1);
    check("t2_drop", 32'(read1), 32'd0);
    check("t2_accepts", 32'(acc1), 32'd9);
    tick(5);
    check("t2_cnt", 32'(outq1.size()), 32'd3);
    check("t2_out", outq1[2], 32'h18);
    check("t2_kept", 32'(kc1), 32'd3);
    check("t2_busy", 32'(busy1), 32'd0);

    // Backpressure: credits stop requests once the buffer holds 0x0,0x4,0x8,0xC.
    do_reset();
    st_ready = 1'b0;
    for (int i = 0; i < 40; i++) load1(32'(i));
    enable = 1'b1;
    tick(60);
    check("t3_accepts", 32'(acc1), 32'd16);
    check("t3_kept", 32'(kc1), 32'd4);
    check("t3_read", 32'(read1), 32'd0);
    check("t3_valid", 32'(valid1), 32'd1);
    check("t3_head", data1, 32'h0);
    st_ready = 1'b1;
    tick(60);
    check("t3_cnt", 32'(outq1.size()), 32'd10);
    check("t3_out3", outq1[3], 32'hC);
    check("t3_out4", outq1[4], 32'h10);
    check("t3_out9", outq1[9], 32'h24);
    check("t3_kept2", 32'(kc1), 32'd10);
    check("t3_ovf", 32'(ovf), 32'd0);

    // Reset one cycle after 0x20 is accepted: 0x20 is discarded, and the slave also
    // pops 0x21 on the reset edge, so 0x22 is the next accepted (kept) read.
    enable = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) load1(32'h20 + 32'(i));
    enable = 1'b1;
    for (int i = 0; i < 20 && acc1 < 1; i++) tick(1);
    check("t4_acc_seen", 32'(acc1), 32'd1);
    rst_n = 1'b0;
    tick(1);
    check("t4_valid", 32'(valid1), 32'd0);
    check("t4_kept0", 32'(kc1), 32'd0);
    rst_n = 1'b1;
    tick(30);
    check("t4_cnt", 32'(outq1.size()), 32'd2);
    check("t4_out0", outq1[0], 32'h22);
    check("t4_out1", outq1[1], 32'h26);
    check("t4_kept", 32'(kc1), 32'd2);
`endif

    // DECIM=1, READ_LATENCY=2: every word passes, one per cycle.
    for (int i = 0; i < 100; i++) begin
      mem2[wr2] = 32'(i);
      wr2++;
    end
    enable2 = 1'b1; st_ready2 = 1'b1;
    tick(150);
    check("t5_cnt", 32'(out2.size()), 32'd100);
    for (int i = 0; i < 100 && i < out2.size(); i++)
      check("t5_data", out2[i], 32'(i));
    check("t5_kept", 32'(kc2), 32'd100);
    check("t5_rate", 32'(last2 - first2), 32'd99);
    check("ovf_final", 32'(ovf), 32'd0);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
